// File: rtl/fft_fund_bin_pick_pkg.sv
// Shared types and helpers for the FFT fundamental-bin picker: state encoding,
// default widths and the |re|+|im| magnitude used for peak ranking.
package fft_fund_bin_pick_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam int BIN_W_DEF = 13;
  localparam int MAG_W_DEF = 17;
  localparam int SMP_W     = 16;

  // One extra bit keeps the sum exact: -32768 maps to 32768, peak value 65536.
  function automatic logic [SMP_W:0] abs_sum(input logic signed [SMP_W-1:0] re,
                                             input logic signed [SMP_W-1:0] im);
    logic signed [SMP_W:0] re_x, im_x;
    logic        [SMP_W:0] re_a, im_a;
    re_x = re;
    im_x = im;
    re_a = re_x[SMP_W] ? unsigned'(-re_x) : unsigned'(re_x);
    im_a = im_x[SMP_W] ? unsigned'(-im_x) : unsigned'(im_x);
    return re_a + im_a;
  endfunction

endpackage

// File: rtl/fft_fund_bin_pick_peak_tracker.sv
// Stage-2 running-maximum tracker: keeps the strongest candidate bin of the
// current frame; outputs already include the beat being presented this cycle.
module fbp_peak_tracker
  import fft_fund_bin_pick_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int MAG_W  = MAG_W_DEF,
  parameter int DATA_W = 4 * SMP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              candidate_en_i,
  input  logic [MAG_W-1:0]  mag_i,
  input  logic [BIN_W-1:0]  bin_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [MAG_W-1:0]  max_o,
  output logic [BIN_W-1:0]  bin_o,
  output logic [DATA_W-1:0] data_o
);

  logic [MAG_W-1:0]  max_q, max_d, base_mag;
  logic [BIN_W-1:0]  bin_q, bin_d, base_bin;
  logic [DATA_W-1:0] data_q, data_d, base_data;
  logic              take;

  // Strict compare: with ascending bins, the first of equal peaks is kept.
  always_comb begin
    base_mag  = clear_i ? '0 : max_q;
    base_bin  = clear_i ? '0 : bin_q;
    base_data = clear_i ? '0 : data_q;
    take      = candidate_en_i && (mag_i > base_mag);
    max_d     = take ? mag_i  : base_mag;
    bin_d     = take ? bin_i  : base_bin;
    data_d    = take ? data_i : base_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q  <= '0;
      bin_q  <= '0;
      data_q <= '0;
    end else begin
      max_q  <= max_d;
      bin_q  <= bin_d;
      data_q <= data_d;
    end
  end

  assign max_o  = max_d;
  assign bin_o  = bin_d;
  assign data_o = data_d;

endmodule

// File: rtl/fft_fund_bin_pick.sv
// Picks the strongest ch1 bin in the lower half of each FFT frame and reports
// both channels' complex values at that bin two cycles after the last beat.
module fft_fund_bin_pick
  import fft_fund_bin_pick_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int MAG_W = MAG_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [SMP_W-1:0] fft_ch1_re,
  input  logic signed [SMP_W-1:0] fft_ch1_im,
  input  logic signed [SMP_W-1:0] fft_ch2_re,
  input  logic signed [SMP_W-1:0] fft_ch2_im,
  input  logic                    fft_valid,
  input  logic                    fft_last,
  input  logic [BIN_W-1:0]        fft_index,
  input  logic                    enable,
  input  logic [MAG_W-1:0]        min_mag,
  output logic signed [SMP_W-1:0] ch1_re,
  output logic signed [SMP_W-1:0] ch1_im,
  output logic signed [SMP_W-1:0] ch2_re,
  output logic signed [SMP_W-1:0] ch2_im,
  output logic                    ch1_valid,
  output logic                    ch2_valid,
  output logic [BIN_W-1:0]        peak_bin,
  output logic [MAG_W-1:0]        peak_mag,
  output logic                    no_signal,
  output logic                    frame_err
);

  localparam int DATA_W = 4 * SMP_W;

  state_e state_q, state_d;
  logic   acc, start, err, last_acc, is_zero;

  always_comb begin
    state_d  = state_q;
    acc      = 1'b0;
    start    = 1'b0;
    err      = 1'b0;
    last_acc = 1'b0;
    is_zero  = (fft_index == '0);
    case (state_q)
      SCAN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (fft_valid) begin
          acc = 1'b1;
          if (is_zero) begin
            start = 1'b1;
            err   = 1'b1;
          end
          if (fft_last) begin
            last_acc = 1'b1;
            state_d  = EMIT;
          end
        end
      end
      default: begin
        // EMIT accepts a new bin 0 so back-to-back frames need no idle beat.
        state_d = IDLE;
        if (fft_valid && enable && is_zero) begin
          acc      = 1'b1;
          start    = 1'b1;
          last_acc = fft_last;
          state_d  = fft_last ? EMIT : SCAN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Stage 1: register the beat, its magnitude and qualified flags.
  logic              vld_p1_q, start_p1_q, last_p1_q;
  logic [DATA_W-1:0] data_p1_q;
  logic [BIN_W-1:0]  bin_p1_q;
  logic [MAG_W-1:0]  mag_p1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      start_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
    end else begin
      vld_p1_q   <= acc;
      start_p1_q <= start;
      last_p1_q  <= last_acc;
    end
  end

  always_ff @(posedge clk) begin
    data_p1_q <= {fft_ch1_re, fft_ch1_im, fft_ch2_re, fft_ch2_im};
    bin_p1_q  <= fft_index;
    mag_p1_q  <= MAG_W'(abs_sum(fft_ch1_re, fft_ch1_im));
  end

  // Stage 2: running maximum over bins 1 .. N/2-1.
  logic              cand_p1, emit_p1, hit;
  logic [MAG_W-1:0]  trk_mag;
  logic [BIN_W-1:0]  trk_bin;
  logic [DATA_W-1:0] trk_data;

  assign cand_p1 = vld_p1_q && (bin_p1_q != '0) && !bin_p1_q[BIN_W-1];
  assign emit_p1 = vld_p1_q && last_p1_q;
  assign hit     = (trk_mag >= min_mag);

  fbp_peak_tracker #(
    .BIN_W  (BIN_W),
    .MAG_W  (MAG_W),
    .DATA_W (DATA_W)
  ) u_tracker (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (vld_p1_q && start_p1_q),
    .candidate_en_i (cand_p1),
    .mag_i          (mag_p1_q),
    .bin_i          (bin_p1_q),
    .data_i         (data_p1_q),
    .max_o          (trk_mag),
    .bin_o          (trk_bin),
    .data_o         (trk_data)
  );

  logic              res_vld_q, no_signal_q, frame_err_q;
  logic [DATA_W-1:0] out_data_q;
  logic [BIN_W-1:0]  peak_bin_q;
  logic [MAG_W-1:0]  peak_mag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld_q   <= 1'b0;
      no_signal_q <= 1'b0;
      frame_err_q <= 1'b0;
      out_data_q  <= '0;
      peak_bin_q  <= '0;
      peak_mag_q  <= '0;
    end else begin
      res_vld_q   <= emit_p1 && hit;
      no_signal_q <= emit_p1 && !hit;
      frame_err_q <= err;
      if (emit_p1 && hit) begin
        out_data_q <= trk_data;
        peak_bin_q <= trk_bin;
        peak_mag_q <= trk_mag;
      end
    end
  end

  assign ch1_re    = out_data_q[4*SMP_W-1 -: SMP_W];
  assign ch1_im    = out_data_q[3*SMP_W-1 -: SMP_W];
  assign ch2_re    = out_data_q[2*SMP_W-1 -: SMP_W];
  assign ch2_im    = out_data_q[SMP_W-1   -: SMP_W];
  assign ch1_valid = res_vld_q;
  assign ch2_valid = res_vld_q;
  assign peak_bin  = peak_bin_q;
  assign peak_mag  = peak_mag_q;
  assign no_signal = no_signal_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_fund_bin_pick.sv
// Directed-plus-random bench for fft_fund_bin_pick; expected peaks come from a
// frame-level reference model over the list of beats sent in each frame.
module tb_fft_fund_bin_pick;

  localparam int BIN_W = 13;
  localparam int MAG_W = 17;
  localparam int HALF  = 1 << (BIN_W - 1);

  logic               clk, rst_n;
  logic signed [15:0] fft_ch1_re, fft_ch1_im, fft_ch2_re, fft_ch2_im;
  logic               fft_valid, fft_last, enable;
  logic [BIN_W-1:0]   fft_index;
  logic [MAG_W-1:0]   min_mag;
  logic signed [15:0] ch1_re, ch1_im, ch2_re, ch2_im;
  logic               ch1_valid, ch2_valid, no_signal, frame_err;
  logic [BIN_W-1:0]   peak_bin;
  logic [MAG_W-1:0]   peak_mag;

  fft_fund_bin_pick #(.BIN_W(BIN_W), .MAG_W(MAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fft_ch1_re(fft_ch1_re), .fft_ch1_im(fft_ch1_im),
    .fft_ch2_re(fft_ch2_re), .fft_ch2_im(fft_ch2_im),
    .fft_valid(fft_valid), .fft_last(fft_last), .fft_index(fft_index),
    .enable(enable), .min_mag(min_mag),
    .ch1_re(ch1_re), .ch1_im(ch1_im), .ch2_re(ch2_re), .ch2_im(ch2_im),
    .ch1_valid(ch1_valid), .ch2_valid(ch2_valid),
    .peak_bin(peak_bin), .peak_mag(peak_mag),
    .no_signal(no_signal), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    logic signed [15:0] c1r, c1i, c2r, c2i;
  } beat_t;

  typedef struct {
    int mag;
    int bin;
    logic signed [15:0] c1r, c1i, c2r, c2i;
  } res_t;

  beat_t fq[$];
  res_t  hold, expa;
  bit    open_frame;
  int    n_pass = 0, n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: strongest |re|+|im| of ch1 among bins 1..N/2-1, first one wins.
  function automatic res_t model();
    res_t r;
    r = '{mag: 0, bin: 0, c1r: 0, c1i: 0, c2r: 0, c2i: 0};
    foreach (fq[i]) begin
      int m;
      m = iabs(int'(fq[i].c1r)) + iabs(int'(fq[i].c1i));
      if (fq[i].idx >= 1 && fq[i].idx < HALF && m > r.mag)
        r = '{mag: m, bin: fq[i].idx, c1r: fq[i].c1r, c1i: fq[i].c1i,
              c2r: fq[i].c2r, c2i: fq[i].c2i};
    end
    return r;
  endfunction

  function automatic logic signed [15:0] rfull();
    return 16'($urandom);
  endfunction

  function automatic logic signed [15:0] rsmall(input int amp);
    return 16'(int'($urandom_range(2 * amp, 0)) - amp);
  endfunction

  task automatic build(input int first, input int last_idx, input int amp);
    fq.delete();
    for (int i = first; i <= last_idx; i++) begin
      if (amp == 0) fq.push_back('{i, rfull(), rfull(), rfull(), rfull()});
      else          fq.push_back('{i, rsmall(amp), rsmall(amp), rsmall(amp), rsmall(amp)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input beat_t b, input bit last);
    fft_index  = BIN_W'(b.idx);
    fft_ch1_re = b.c1r; fft_ch1_im = b.c1i;
    fft_ch2_re = b.c2r; fft_ch2_im = b.c2i;
    fft_valid  = 1'b1;
    fft_last   = last;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
    fft_last  = 1'b0;
  endtask

  task automatic send_frame(input int from, input int gapmax, input bit do_last);
    for (int i = from; i < fq.size(); i++) begin
      bit lst;
      lst = do_last && (i == fq.size() - 1);
      if (gapmax > 0) idle($urandom_range(gapmax, 0));
      beat(fq[i], lst);
      if (fq[i].idx == 0) chk("frame_err_at_bin0", frame_err, open_frame);
      open_frame = !lst;
    end
  endtask

  task automatic check_data(input string tag);
    chk({tag, ".peak_bin"}, peak_bin, hold.bin);
    chk({tag, ".peak_mag"}, peak_mag, hold.mag);
    chk({tag, ".ch1_re"},   ch1_re,   hold.c1r);
    chk({tag, ".ch1_im"},   ch1_im,   hold.c1i);
    chk({tag, ".ch2_re"},   ch2_re,   hold.c2r);
    chk({tag, ".ch2_im"},   ch2_im,   hold.c2i);
  endtask

  // Called at T+2 (one edge after the last beat was sampled and registered).
  task automatic check_out(input string tag, input bit exp_v, input bit exp_ns, input res_t r);
    if (exp_v) hold = r;
    chk({tag, ".ch1_valid"}, ch1_valid, exp_v);
    chk({tag, ".ch2_valid"}, ch2_valid, exp_v);
    chk({tag, ".no_signal"}, no_signal, exp_ns);
    check_data(tag);
    idle(1);
    chk({tag, ".valid_one_cycle"}, ch1_valid, 1'b0);
    chk({tag, ".no_signal_one_cycle"}, no_signal, 1'b0);
  endtask

  task automatic end_frame(input string tag, input bit produces);
    res_t r;
    bit   v;
    r = model();
    v = produces && (r.mag >= int'(min_mag));
    chk({tag, ".valid_not_early"}, ch1_valid, 1'b0);
    idle(1);
    check_out(tag, v, produces && !v, r);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; min_mag = MAG_W'(100);
    fft_valid = 1'b0; fft_last = 1'b0; fft_index = '0;
    fft_ch1_re = 0; fft_ch1_im = 0; fft_ch2_re = 0; fft_ch2_im = 0;
    hold = '{mag: 0, bin: 0, c1r: 0, c1i: 0, c2r: 0, c2i: 0};
    open_frame = 1'b0;
    idle(2);
    chk("reset.ch1_valid", ch1_valid, 1'b0);
    chk("reset.no_signal", no_signal, 1'b0);
    chk("reset.frame_err", frame_err, 1'b0);
    check_data("reset");
    rst_n = 1'b1;
    idle(1);

    // Single strong bin at 100 over a flat floor.
    fq.delete();
    for (int i = 0; i <= 120; i++) fq.push_back('{i, 16'sd10, 16'sd10, 16'sd10, 16'sd10});
    fq[100].c1r = 1000; fq[100].c1i = 0; fq[100].c2r = 0; fq[100].c2i = 1000;
    send_frame(0, 2, 1);
    end_frame("peak100", 1);

    // Large DC ignored; equal peaks at 50 and 60 resolve to 50.
    build(0, 70, 200);
    fq[0].c1r = 30000; fq[0].c1i = 0;
    fq[50].c1r = 500; fq[50].c1i = 500;
    fq[60].c1r = 500; fq[60].c1i = 500;
    send_frame(0, 1, 1);
    end_frame("dc_tie", 1);

    // Most negative sample in both parts.
    build(0, 20, 0);
    fq[7].c1r = -32768; fq[7].c1i = -32768;
    send_frame(0, 1, 1);
    end_frame("extreme", 1);

    // Sparse frame: last candidate bin vs stronger mirrored bins.
    build(0, 30, 200);
    fq.push_back('{HALF - 1, 16'sd3000, -16'sd3000, rfull(), rfull()});
    fq.push_back('{HALF, 16'sd20000, 16'sd0, rfull(), rfull()});
    fq.push_back('{2 * HALF - 1, 16'sd25000, 16'sd0, rfull(), rfull()});
    send_frame(0, 1, 1);
    end_frame("mirror", 1);

    // Below threshold: no_signal, outputs held.
    min_mag = MAG_W'(2000);
    build(0, 40, 300);
    fq[12].c1r = 1000; fq[12].c1i = -500;
    send_frame(0, 1, 1);
    end_frame("threshold", 1);
    min_mag = MAG_W'(100);

    // Index jumps back to 0 at bin 300: frame_err then a clean frame.
    build(0, 299, 300);
    send_frame(0, 0, 0);
    build(0, 90, 0);
    send_frame(0, 1, 1);
    end_frame("restart", 1);

    // Reset at bin 500.
    build(0, 500, 300);
    send_frame(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    hold = '{mag: 0, bin: 0, c1r: 0, c1i: 0, c2r: 0, c2i: 0};
    chk("midreset.ch1_valid", ch1_valid, 1'b0);
    check_data("midreset");
    idle(1);
    rst_n = 1'b1;
    open_frame = 1'b0;
    build(501, 520, 0);
    send_frame(0, 1, 1);
    end_frame("after_reset_tail", 0);
    build(0, 60, 0);
    send_frame(0, 1, 1);
    end_frame("after_reset_frame", 1);

    // Enable dropped mid-frame.
    build(0, 39, 0);
    send_frame(0, 1, 0);
    enable = 1'b0;
    idle(2);
    enable = 1'b1;
    open_frame = 1'b0;
    build(40, 80, 0);
    send_frame(0, 1, 1);
    end_frame("enable_abort", 0);
    build(0, 50, 0);
    send_frame(0, 1, 1);
    end_frame("after_abort", 1);

    // Back-to-back frames: B's bin 0 follows A's last directly.
    build(0, 60, 0);
    expa = model();
    send_frame(0, 0, 1);
    chk("b2b_a.valid_not_early", ch1_valid, 1'b0);
    build(0, 45, 0);
    beat(fq[0], 1'b0);
    chk("b2b_b.frame_err", frame_err, 1'b0);
    open_frame = 1'b1;
    check_out("b2b_a", expa.mag >= int'(min_mag), expa.mag < int'(min_mag), expa);
    send_frame(1, 0, 1);
    end_frame("b2b_b", 1);

    // Random frames with gaps.
    for (int k = 0; k < 3; k++) begin
      build(0, int'($urandom_range(150, 20)), 0);
      send_frame(0, 2, 1);
      end_frame($sformatf("rand%0d", k), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
